jk_reg_bank: RTL and testbench
==============================

// Module: jk_reg_bank
// PURPOSE
//   WIDTH-bit register bank built from JK cells, with three operating modes: per-bit JK,
//   up/down modulo counter, and serial shift. It is the general storage/counting
//   primitive for datapath and sequencer blocks, replacing the single-bit jkff.
//   All state changes on the rising clk edge and only while en=1.
// PARAMETERS
//   WIDTH      8             number of JK bits in the bank (>=2)
//   RESET_VAL  {WIDTH{1'b0}} value loaded into q on reset
//   MAX_COUNT  2**WIDTH-1    counter terminal value; MAX_COUNT >= 2**WIDTH is an elaboration error
// PORTS
//   clk      in   1      rising-edge clock
//   rst      in   1      synchronous, active-high reset
//   en       in   1      clock enable; 0 -> all state holds (tc still clears)
//   mode     in   2      00 JK, 01 COUNT, 10 SHIFT, 11 HOLD
//   j        in   WIDTH  per-bit J inputs (used in JK mode only)
//   k        in   WIDTH  per-bit K inputs (used in JK mode only)
//   dir      in   1      COUNT mode: 1 = up, 0 = down
//   ser_in   in   1      SHIFT mode: serial input, enters at bit 0
//   q        out  WIDTH  registered bank state
//   ser_out  out  1      combinational: q[WIDTH-1]
//   tc       out  1      registered terminal-count pulse
// BEHAVIOUR
//   Reset: when rst=1 at a clk edge: q<=RESET_VAL, tc<=0. Reset has priority over en and mode.
//     Reset asserted mid-count or mid-shift discards the operation in that cycle.
//   en=0: q holds and tc<=0. mode, j, k, dir and ser_in are ignored.
//   JK (00), per bit i:
//     j=0,k=0 -> hold
//     j=0,k=1 -> 0
//     j=1,k=0 -> 1
//     j=1,k=1 -> ~q[i]
//     tc<=0.
//   COUNT (01), up:
//     q==MAX_COUNT -> q<=0, tc<=1
//     else q<=q+1, tc<=0
//   COUNT (01), down:
//     q==0 -> q<=MAX_COUNT, tc<=1
//     else q<=q-1, tc<=0
//   COUNT arithmetic:
//     unsigned, WIDTH bits.
//     If q>MAX_COUNT on entry (from JK/SHIFT/RESET_VAL), counting up wraps to 0 with tc<=1.
//     Counting down from such a value decrements normally.
//   SHIFT (10): q<={q[WIDTH-2:0],ser_in}; tc<=0.
//   HOLD (11): q holds; tc<=0.
//   tc timing: high for exactly one cycle, in the cycle after the wrap edge.
//     Back-to-back wraps (MAX_COUNT=0 is not allowed; MAX_COUNT=1 is) give consecutive tc pulses.
//   mode changes take effect on the next edge; no pipeline, latency = 1 clk for q.
// CONFIGURATION
//   JKBANK_SAT_EN defined:
//     COUNT saturates instead of wrapping: up at MAX_COUNT holds MAX_COUNT, down at 0 holds 0.
//     tc<=1 on every enabled COUNT edge where q is held at the limit.
//     Up from q>MAX_COUNT loads MAX_COUNT.
//   JKBANK_SAT_EN undefined: wrap behaviour as above. Port list is identical in both builds.
// STRUCTURE
//   Package jk_pkg:
//     mode encodings MODE_JK, MODE_COUNT, MODE_SHIFT, MODE_HOLD
//     typedef jk_mode_t (2-bit)
//   Sub-module jk_cell (clk, rst, rst_val, en, j, k, q):
//     one synchronous JK bit, instantiated WIDTH times via generate.
//   Bank level:
//     maps mode/dir/ser_in/wrap condition onto per-cell j/k
//     COUNT toggle: j=k=1 when all lower bits are 1 (up) or 0 (down)
//     wrap: force j=0,k=1 (clear) or load MAX_COUNT via j=bit, k=~bit
//     SHIFT: j=src, k=~src
//   The tc register lives at bank level.
// TESTING
//   1. WIDTH=8, rst=1 for 1 edge, en=1 -> q=8'h00, tc=0.
//      RESET_VAL=8'hA5 build -> q=8'hA5.
//   2. JK mode from q=8'h0F:
//      j=8'hF0, k=8'h00 -> q=8'hFF.
//      Then j=k=8'h3C -> q=8'hC3.
//      Then j=0, k=8'hFF -> q=8'h00.
//   3. COUNT up with MAX_COUNT=9 from q=8 -> q 9, 0, 1.
//      tc=1 only in the cycle after the 9->0 edge.
//      dir=0 from q=0 -> q=9, tc pulse.
//   4. SHIFT from q=8'h00, ser_in pattern 1,0,1,1 -> q=8'h0B.
//      ser_out tracks q[7]; 8 more ones -> q=8'hFF.
//   5. en=0 during COUNT at q=5 for 3 edges -> q stays 5, tc=0.
//      rst asserted mid-count at q=7 -> q=RESET_VAL next edge.
//   6. JKBANK_SAT_EN build, MAX_COUNT=9, q=9, up for 3 edges -> q=9, tc=1 each cycle.
//      Down from 0 -> q=0, tc=1.

Source files
------------

// File: rtl/jk_pkg.sv
// Shared mode encodings for the JK register bank.
package jk_pkg;

  typedef enum logic [1:0] {
    MODE_JK    = 2'b00,
    MODE_COUNT = 2'b01,
    MODE_SHIFT = 2'b10,
    MODE_HOLD  = 2'b11
  } jk_mode_t;

endpackage

// File: rtl/jk_cell.sv
// Single synchronous JK storage bit with clock enable and loadable reset value.
module jk_cell (
  input  logic clk,
  input  logic rst,
  input  logic rst_val,
  input  logic en,
  input  logic j,
  input  logic k,
  output logic q
);

  logic r_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= rst_val;
    end else if (en) begin
      case ({j, k})
        2'b01:   r_q <= 1'b0;
        2'b10:   r_q <= 1'b1;
        2'b11:   r_q <= ~r_q;
        default: r_q <= r_q;
      endcase
    end
  end

  assign q = r_q;

endmodule

// File: rtl/jk_reg_bank.sv
// WIDTH-bit JK register bank: per-bit JK, up/down modulo counter, serial shift.
// Define JKBANK_SAT_EN to make COUNT saturate at the limits instead of wrapping.
module jk_reg_bank
  import jk_pkg::*;
#(
  parameter int unsigned       WIDTH     = 8,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0,
  parameter int unsigned       MAX_COUNT = 2**WIDTH - 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  input  logic             dir,
  input  logic             ser_in,
  output logic [WIDTH-1:0] q,
  output logic             ser_out,
  output logic             tc
);

  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("jk_reg_bank: WIDTH must be in 2..32");
  end
  if (MAX_COUNT == 0 || (64'(MAX_COUNT) >> WIDTH) != 64'd0) begin : g_bad_max
    $error("jk_reg_bank: MAX_COUNT must be in 1..2**WIDTH-1");
  end

  localparam logic [WIDTH-1:0] MAXV = MAX_COUNT[WIDTH-1:0];

  jk_mode_t         w_mode;
  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_j;
  logic [WIDTH-1:0] w_k;
  logic [WIDTH-1:0] w_ones;
  logic [WIDTH-1:0] w_zeros;
  logic [WIDTH-1:0] w_shift;
  logic             w_at_top;
  logic             w_at_max;
  logic             w_at_zero;
  logic             w_tc;
  logic             r_tc;

  assign w_mode    = jk_mode_t'(mode);
  assign w_at_max  = (w_q == MAXV);
  assign w_at_top  = (w_q >= MAXV);
  assign w_at_zero = (w_q == '0);
  assign w_shift   = {w_q[WIDTH-2:0], ser_in};

  // Bit i toggles when every lower bit is 1 (up) or 0 (down).
  always_comb begin
    w_ones     = '0;
    w_zeros    = '0;
    w_ones[0]  = 1'b1;
    w_zeros[0] = 1'b1;
    for (int i = 1; i < int'(WIDTH); i++) begin
      w_ones[i]  = w_ones[i-1]  &  w_q[i-1];
      w_zeros[i] = w_zeros[i-1] & ~w_q[i-1];
    end
  end

  always_comb begin
    w_j  = '0;
    w_k  = '0;
    w_tc = 1'b0;
    case (w_mode)
      MODE_JK: begin
        w_j = j;
        w_k = k;
      end
      MODE_COUNT: begin
        if (dir) begin
`ifdef JKBANK_SAT_EN
          if (w_at_max) begin
            w_tc = 1'b1;
          end else if (w_at_top) begin
            w_j = MAXV;
            w_k = ~MAXV;
          end else begin
            w_j = w_ones;
            w_k = w_ones;
          end
`else
          if (w_at_top) begin
            w_k  = '1;
            w_tc = 1'b1;
          end else begin
            w_j = w_ones;
            w_k = w_ones;
          end
`endif
        end else begin
          if (w_at_zero) begin
            w_tc = 1'b1;
`ifndef JKBANK_SAT_EN
            w_j  = MAXV;
            w_k  = ~MAXV;
`endif
          end else begin
            w_j = w_zeros;
            w_k = w_zeros;
          end
        end
      end
      MODE_SHIFT: begin
        w_j = w_shift;
        w_k = ~w_shift;
      end
      default: begin
        w_j = '0;
        w_k = '0;
      end
    endcase
  end

  for (genvar i = 0; i < int'(WIDTH); i++) begin : g_cell
    jk_cell u_cell (
      .clk     (clk),
      .rst     (rst),
      .rst_val (RESET_VAL[i]),
      .en      (en),
      .j       (w_j[i]),
      .k       (w_k[i]),
      .q       (w_q[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) r_tc <= 1'b0;
    else     r_tc <= en & w_tc;
  end

  assign q       = w_q;
  assign ser_out = w_q[WIDTH-1];
  assign tc      = r_tc;

endmodule

// File: tb/tb_jk_reg_bank.sv
// Directed + random scoreboard bench for jk_reg_bank (WIDTH=8, RESET_VAL=A5, MAX_COUNT=9).
module tb_jk_reg_bank;

  localparam logic [7:0] RV   = 8'hA5;
  localparam logic [7:0] MAXC = 8'd9;

  logic       clk = 1'b0;
  logic       rst = 1'b1, en = 1'b1, dir = 1'b1, ser_in = 1'b0;
  logic [1:0] mode = 2'b11;
  logic [7:0] j = '0, k = '0;
  logic [7:0] q;
  logic       ser_out, tc;

  always #5 clk = ~clk;

  jk_reg_bank #(.WIDTH(8), .RESET_VAL(RV), .MAX_COUNT(9)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .j(j), .k(k),
    .dir(dir), .ser_in(ser_in), .q(q), .ser_out(ser_out), .tc(tc)
  );

  typedef struct packed {
    logic [7:0] q;
    logic       tc;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] m_q = RV;
  int         total = 0;
  int         bad   = 0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] ex);
    total++;
    assert (obs === ex) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, ex);
    end
  endtask

  function automatic exp_t model(input logic [7:0] cq, input logic r, input logic e,
                                 input logic [1:0] md, input logic [7:0] jj,
                                 input logic [7:0] kk, input logic d, input logic s);
    exp_t x;
    x.q  = cq;
    x.tc = 1'b0;
    if (r) begin
      x.q = RV;
    end else if (e) begin
      case (md)
        2'b00: for (int i = 0; i < 8; i++)
                 case ({jj[i], kk[i]})
                   2'b01:   x.q[i] = 1'b0;
                   2'b10:   x.q[i] = 1'b1;
                   2'b11:   x.q[i] = ~cq[i];
                   default: ;
                 endcase
        2'b01: begin
          if (d) begin
            if (cq == MAXC) begin
              x.tc = 1'b1;
`ifndef JKBANK_SAT_EN
              x.q = 8'd0;
`endif
            end else if (cq > MAXC) begin
`ifdef JKBANK_SAT_EN
              x.q = MAXC;
`else
              x.q  = 8'd0;
              x.tc = 1'b1;
`endif
            end else begin
              x.q = cq + 8'd1;
            end
          end else if (cq == 8'd0) begin
            x.tc = 1'b1;
`ifndef JKBANK_SAT_EN
            x.q = MAXC;
`endif
          end else begin
            x.q = cq - 8'd1;
          end
        end
        2'b10:   x.q = {cq[6:0], s};
        default: ;
      endcase
    end
    return x;
  endfunction

  task automatic step(input string tag, input logic r, input logic e, input logic [1:0] md,
                      input logic [7:0] jj, input logic [7:0] kk, input logic d, input logic s);
    exp_t x;
    rst = r; en = e; mode = md; j = jj; k = kk; dir = d; ser_in = s;
    x = model(m_q, r, e, md, jj, kk, d, s);
    m_q = x.q;
    sb.push_back(x);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    chk({tag, ".q"},  q, x.q);
    chk({tag, ".tc"}, {7'b0, tc}, {7'b0, x.tc});
    chk({tag, ".so"}, {7'b0, ser_out}, {7'b0, x.q[7]});
  endtask

  task automatic jk(input string tag, input logic [7:0] jj, input logic [7:0] kk);
    step(tag, 1'b0, 1'b1, 2'b00, jj, kk, 1'b0, 1'b0);
  endtask

  task automatic cnt(input string tag, input logic d);
    step(tag, 1'b0, 1'b1, 2'b01, 8'h00, 8'h00, d, 1'b0);
  endtask

  task automatic sh(input string tag, input logic s);
    step(tag, 1'b0, 1'b1, 2'b10, 8'h00, 8'h00, 1'b0, s);
  endtask

  initial begin
    // reset
    step("rst", 1'b1, 1'b1, 2'b01, 8'hFF, 8'h00, 1'b1, 1'b1);
    chk("rst_const", q, 8'hA5);
    chk("rst_tc", {7'b0, tc}, 8'h00);

    // JK mode from 0F
    jk("jk_ld0f", 8'h0F, 8'hF0);
    jk("jk_set", 8'hF0, 8'h00);
    chk("jk_ff", q, 8'hFF);
    jk("jk_tog", 8'h3C, 8'h3C);
    chk("jk_c3", q, 8'hC3);
    jk("jk_clr", 8'h00, 8'hFF);
    chk("jk_00", q, 8'h00);
    step("hold", 1'b0, 1'b1, 2'b11, 8'hFF, 8'h00, 1'b1, 1'b1);

    // COUNT up from 8 across the wrap / saturation point
    jk("ld8", 8'h08, 8'hF7);
    cnt("up9", 1'b1);
    cnt("upw", 1'b1);
    cnt("up1", 1'b1);
`ifdef JKBANK_SAT_EN
    chk("sat_hold", q, 8'd9);
    chk("sat_tc", {7'b0, tc}, 8'h01);
`else
    chk("wrap_q", q, 8'd1);
    chk("wrap_tc", {7'b0, tc}, 8'h00);
`endif
    jk("clr", 8'h00, 8'hFF);
    cnt("dn0", 1'b0);
    chk("dn0_tc", {7'b0, tc}, 8'h01);
    cnt("dn1", 1'b0);

    // entry above MAX_COUNT
    jk("ldc8", 8'hC8, 8'h37);
    cnt("dn_hi", 1'b0);
    chk("dn_hi_c", q, 8'hC7);
    cnt("up_hi", 1'b1);
    cnt("up_hi2", 1'b1);

    // SHIFT
    jk("clr2", 8'h00, 8'hFF);
    sh("s1", 1'b1); sh("s0", 1'b0); sh("s1b", 1'b1); sh("s1c", 1'b1);
    chk("sh_0b", q, 8'h0B);
    for (int i = 0; i < 8; i++) sh("s_one", 1'b1);
    chk("sh_ff", q, 8'hFF);

    // enable low during COUNT, then reset mid-count
    jk("ld5", 8'h05, 8'hFA);
    for (int i = 0; i < 3; i++) step("en0", 1'b0, 1'b0, 2'b01, 8'hFF, 8'hFF, 1'b1, 1'b1);
    chk("en0_q", q, 8'd5);
    cnt("up6", 1'b1);
    cnt("up7", 1'b1);
    step("rst_mid", 1'b1, 1'b1, 2'b01, 8'h00, 8'h00, 1'b1, 1'b0);
    chk("rst_mid_c", q, RV);

    // random mix, biased toward COUNT
    for (int n = 0; n < 80; n++) begin
      logic [1:0] md;
      md = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'($urandom_range(0, 3));
      step("rnd", ($urandom_range(0, 24) == 0), ($urandom_range(0, 7) != 0), md,
           8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
